// File: rtl/fetch_sequencer.sv
// Program-counter controller for the instruction ROM: start/done handshake,
// stall / absolute-jump / relative-branch redirects and a saturating run-cycle counter.
module fetch_sequencer #(
  parameter int unsigned       D          = 10,
  parameter logic [D-1:0]      START_ADDR = '0,
  parameter int unsigned       OFS_W      = 8,
  parameter int unsigned       CT_W       = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    stall,
  input  logic                    halt,
  input  logic                    abs_jump,
  input  logic                    rel_jump,
  input  logic                    taken,
  input  logic [D-1:0]            target,
  input  logic signed [OFS_W-1:0] offset,
  output logic [D-1:0]            prog_ctr,
  output logic                    instr_valid,
  output logic                    done,
  output logic [CT_W-1:0]         cycle_ct
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state;
  logic   start_q;

  function automatic logic [CT_W-1:0] sat_inc(input logic [CT_W-1:0] ct);
    return (&ct) ? ct : ct + CT_W'(1);
  endfunction

  // Sign-extend the offset to D bits; the add then wraps modulo 2**D in both directions.
  function automatic logic [D-1:0] rel_target(input logic [D-1:0] pc,
                                              input logic signed [OFS_W-1:0] ofs);
    logic signed [D-1:0] ext;
    ext = D'(ofs);
    return pc + $unsigned(ext);
  endfunction

  assign instr_valid = (state == S_RUN);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      start_q  <= 1'b0;
      prog_ctr <= '0;
      done     <= 1'b0;
      cycle_ct <= '0;
    end else begin
      start_q <= start;
      case (state)
        S_IDLE: begin
          prog_ctr <= START_ADDR;
          // Run begins on the falling edge of the host start level.
          if (start_q && !start) begin
            state    <= S_RUN;
            cycle_ct <= '0;
          end
        end
        S_RUN: begin
          cycle_ct <= sat_inc(cycle_ct);
          if (stall) begin
            prog_ctr <= prog_ctr;
          end else if (halt) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else if (abs_jump && taken) begin
            prog_ctr <= target;
          end else if (rel_jump && taken) begin
            prog_ctr <= rel_target(prog_ctr, offset);
          end else if (&prog_ctr) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            prog_ctr <= prog_ctr + D'(1);
          end
        end
        S_DONE: begin
          if (start) begin
            state    <= S_IDLE;
            done     <= 1'b0;
            prog_ctr <= START_ADDR;
          end
        end
        default: begin
          state <= S_IDLE;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed, table-driven bench for fetch_sequencer with hand-computed expectations.
module tb_fetch_sequencer;

  logic              clk = 1'b0;
  logic              reset, start, stall, halt, abs_jump, rel_jump, taken;
  logic [9:0]        target;
  logic signed [7:0] offset;
  logic [9:0]        prog_ctr;
  logic              instr_valid, done;
  logic [15:0]       cycle_ct;

  int total = 0;
  int bad   = 0;

  fetch_sequencer #(.D(10), .START_ADDR(10'd0), .OFS_W(8), .CT_W(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .stall       (stall),
    .halt        (halt),
    .abs_jump    (abs_jump),
    .rel_jump    (rel_jump),
    .taken       (taken),
    .target      (target),
    .offset      (offset),
    .prog_ctr    (prog_ctr),
    .instr_valid (instr_valid),
    .done        (done),
    .cycle_ct    (cycle_ct)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       st, sl, hl, aj, rj, tk;
    logic [9:0] tgt;
    logic [7:0] ofs;
    logic [9:0] e_pc;
    logic       e_vld, e_done;
    logic [15:0] e_ct;
  } vec_t;

  vec_t vecs[28];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int pc, input int vld,
                           input int dn, input int ct);
    check({tag, ".pc"},   int'(prog_ctr),    pc);
    check({tag, ".vld"},  int'(instr_valid), vld);
    check({tag, ".done"}, int'(done),        dn);
    check({tag, ".ct"},   int'(cycle_ct),    ct);
  endtask

  task automatic clear_in();
    start = 0; stall = 0; halt = 0; abs_jump = 0; rel_jump = 0; taken = 0;
    target = '0; offset = '0;
  endtask

  initial begin
    // fields: start stall halt abs rel taken target offset | pc vld done ct
    vecs[0]  = '{0,0,0,0,0,0, 10'd0,    8'h00,  10'd1,    1,0, 16'd1};
    vecs[1]  = '{0,0,0,0,0,0, 10'd0,    8'h00,  10'd2,    1,0, 16'd2};
    vecs[2]  = '{0,0,0,0,0,0, 10'd0,    8'h00,  10'd3,    1,0, 16'd3};
    vecs[3]  = '{0,0,0,0,0,0, 10'd0,    8'h00,  10'd4,    1,0, 16'd4};
    vecs[4]  = '{0,0,0,0,0,0, 10'd0,    8'h00,  10'd5,    1,0, 16'd5};
    vecs[5]  = '{0,0,0,1,0,1, 10'd3,    8'h00,  10'd3,    1,0, 16'd6};
    vecs[6]  = '{0,0,0,0,1,1, 10'd0,    8'hFE,  10'd1,    1,0, 16'd7};
    vecs[7]  = '{0,0,0,1,1,1, 10'd100,  8'h05,  10'd100,  1,0, 16'd8};
    vecs[8]  = '{0,0,0,0,1,0, 10'd0,    8'h05,  10'd101,  1,0, 16'd9};
    vecs[9]  = '{0,0,0,1,0,0, 10'd50,   8'h00,  10'd102,  1,0, 16'd10};
    vecs[10] = '{0,0,0,1,0,1, 10'd7,    8'h00,  10'd7,    1,0, 16'd11};
    vecs[11] = '{0,1,1,0,0,0, 10'd0,    8'h00,  10'd7,    1,0, 16'd12};
    vecs[12] = '{0,1,1,0,0,0, 10'd0,    8'h00,  10'd7,    1,0, 16'd13};
    vecs[13] = '{0,1,1,1,0,1, 10'd9,    8'h00,  10'd7,    1,0, 16'd14};
    vecs[14] = '{0,0,1,0,0,0, 10'd0,    8'h00,  10'd7,    0,1, 16'd15};
    vecs[15] = '{0,0,0,1,0,1, 10'd9,    8'h00,  10'd7,    0,1, 16'd15};
    vecs[16] = '{1,0,0,0,0,0, 10'd0,    8'h00,  10'd0,    0,0, 16'd15};
    vecs[17] = '{1,0,0,0,0,0, 10'd0,    8'h00,  10'd0,    0,0, 16'd15};
    vecs[18] = '{0,0,0,0,0,0, 10'd0,    8'h00,  10'd0,    1,0, 16'd0};
    vecs[19] = '{0,0,0,1,0,1, 10'd1023, 8'h00,  10'd1023, 1,0, 16'd1};
    vecs[20] = '{0,0,0,0,0,0, 10'd0,    8'h00,  10'd1023, 0,1, 16'd2};
    vecs[21] = '{1,0,0,0,0,0, 10'd0,    8'h00,  10'd0,    0,0, 16'd2};
    vecs[22] = '{0,0,0,0,0,0, 10'd0,    8'h00,  10'd0,    1,0, 16'd0};
    vecs[23] = '{0,0,0,0,0,0, 10'd0,    8'h00,  10'd1,    1,0, 16'd1};
    vecs[24] = '{0,0,0,0,1,1, 10'd0,    8'hFC,  10'd1021, 1,0, 16'd2};
    vecs[25] = '{0,0,0,0,1,1, 10'd0,    8'h05,  10'd2,    1,0, 16'd3};
    vecs[26] = '{0,0,0,0,1,1, 10'd0,    8'h7F,  10'd129,  1,0, 16'd4};
    vecs[27] = '{0,0,0,0,1,1, 10'd0,    8'h80,  10'd1,    1,0, 16'd5};

    clear_in();
    reset = 1;
    tick();
    check_all("reset", 0, 0, 0, 0);

    reset = 0;
    start = 1;
    tick();
    check_all("idle_start_hi", 0, 0, 0, 0);
    tick();
    check_all("idle_start_hi2", 0, 0, 0, 0);
    start = 0;
    tick();
    check_all("run_entry", 0, 1, 0, 0);

    for (int i = 0; i < 28; i++) begin
      start = vecs[i].st; stall = vecs[i].sl; halt = vecs[i].hl;
      abs_jump = vecs[i].aj; rel_jump = vecs[i].rj; taken = vecs[i].tk;
      target = vecs[i].tgt; offset = vecs[i].ofs;
      tick();
      check_all($sformatf("vec%0d", i), int'(vecs[i].e_pc), int'(vecs[i].e_vld),
                int'(vecs[i].e_done), int'(vecs[i].e_ct));
    end

    // Tight loop at address 1 (zero-offset branch) until the counter saturates.
    clear_in();
    rel_jump = 1; taken = 1; offset = 8'h00;
    for (int i = 0; i < 65529; i++) tick();
    check_all("sat_minus1", 1, 1, 0, 65534);
    tick();
    check_all("sat_reach", 1, 1, 0, 65535);
    for (int i = 0; i < 100; i++) tick();
    check_all("sat_hold", 1, 1, 0, 65535);

    // Reset mid-RUN with stall and a taken jump pending.
    abs_jump = 1; taken = 1; target = 10'd500; stall = 1;
    reset = 1;
    tick();
    check_all("reset_midrun", 0, 0, 0, 0);

    // start low with no preceding high must not launch a run.
    clear_in();
    reset = 0;
    tick();
    check_all("idle_no_start", 0, 0, 0, 0);
    tick();
    check_all("idle_no_start2", 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
